// File: rtl/segway_pkg.sv
// Purpose : shared types and constants for the Segway rider sequencing logic.
// Latency : n/a (declarations only).
// Backpress: n/a (declarations only).
package segway_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT     = 2'd1,
    STEER_EN = 2'd2
  } rider_state_t;

  localparam logic [11:0] MIN_RIDER_WT_DEF  = 12'h200;
  localparam logic [11:0] WT_HYSTERESIS_DEF = 12'h040;

  // Settle-timer terminal count widths: all-ones over this many low bits.
  localparam int TMR_BITS_FAST = 15;
  localparam int TMR_BITS_SLOW = 26;

endpackage

// File: rtl/ld_cell_cmp.sv
// Purpose : load-cell weight and left/right balance comparisons.
// Latency : purely combinational.
// Backpress: none; evaluates the latched samples continuously.
// Ports   : lft_q/rght_q latched 12-bit load cells; hyst_hi selects the upper
//           (mount) threshold; sum_ok, diff_gt_1_4, diff_gt_15_16 are the flags.
module ld_cell_cmp
  import segway_pkg::*;
#(
  parameter logic [11:0] MIN_RIDER_WT  = MIN_RIDER_WT_DEF,
  parameter logic [11:0] WT_HYSTERESIS = WT_HYSTERESIS_DEF
) (
  input  logic [11:0] lft_q,
  input  logic [11:0] rght_q,
  input  logic        hyst_hi,
  output logic        sum_ok,
  output logic        diff_gt_1_4,
  output logic        diff_gt_15_16
);

  localparam logic [12:0] THRESH_HI = {1'b0, MIN_RIDER_WT} + {1'b0, WT_HYSTERESIS};
  localparam logic [12:0] THRESH_LO = {1'b0, MIN_RIDER_WT} - {1'b0, WT_HYSTERESIS};

  logic        [12:0] sum;
  logic signed [12:0] sdiff;
  logic signed [12:0] ndiff;
  logic        [11:0] diff;
  logic        [12:0] diff_x;

  always_comb begin
    sum    = {1'b0, lft_q} + {1'b0, rght_q};
    sdiff  = $signed({1'b0, lft_q}) - $signed({1'b0, rght_q});
    ndiff  = -sdiff;
    // Magnitude never exceeds 4095, so the low 12 bits hold it exactly.
    diff   = sdiff[12] ? ndiff[11:0] : sdiff[11:0];
    diff_x = {1'b0, diff};

    diff_gt_1_4   = diff_x > (sum >> 2);
    diff_gt_15_16 = diff_x > (sum - (sum >> 4));
    // Mounting needs more weight than staying on.
    sum_ok        = hyst_hi ? (sum > THRESH_HI) : (sum > THRESH_LO);
  end

endmodule

// File: rtl/rider_steer_seq.sv
// Purpose : rider detect / steering-enable sequencer driving rider_off, en_steer.
// Latency : outputs move 2 clocks after ld_vld (latch, then FSM edge).
// Backpress: none; ld_vld strobes are always accepted, samples hold between.
// Ports   : clk, rst_n (async low); pwr_up; ld_vld with lft_ld/rght_ld 12-bit
//           load cells; en_steer and rider_off registered state decodes.
module rider_steer_seq
  import segway_pkg::*;
#(
  parameter bit          fast_sim      = 1'b1,
  parameter logic [11:0] MIN_RIDER_WT  = MIN_RIDER_WT_DEF,
  parameter logic [11:0] WT_HYSTERESIS = WT_HYSTERESIS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pwr_up,
  input  logic        ld_vld,
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  output logic        en_steer,
  output logic        rider_off
);

  rider_state_t state, nxt_state;

  logic [11:0] lft_q, rght_q;
  logic [25:0] tmr, tmr_nxt;
  logic        tmr_full;
  logic        clr_tmr;
  logic        sum_ok, diff_gt_1_4, diff_gt_15_16;

  // Sample registers: decisions always use the last strobed values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_q  <= 12'h000;
      rght_q <= 12'h000;
    end else if (ld_vld) begin
      lft_q  <= lft_ld;
      rght_q <= rght_ld;
    end
  end

  ld_cell_cmp #(
    .MIN_RIDER_WT (MIN_RIDER_WT),
    .WT_HYSTERESIS(WT_HYSTERESIS)
  ) u_cmp (
    .lft_q        (lft_q),
    .rght_q       (rght_q),
    .hyst_hi      (state == IDLE),
    .sum_ok       (sum_ok),
    .diff_gt_1_4  (diff_gt_1_4),
    .diff_gt_15_16(diff_gt_15_16)
  );

  assign tmr_full = fast_sim ? (&tmr[TMR_BITS_FAST-1:0]) : (&tmr[TMR_BITS_SLOW-1:0]);

  always_comb begin
    nxt_state = state;
    clr_tmr   = 1'b0;
    case (state)
      IDLE: begin
        if (sum_ok) nxt_state = WAIT;
      end
      WAIT: begin
        // Imbalance is checked before expiry so a restart beats tmr_full.
        if (!sum_ok)          nxt_state = IDLE;
        else if (diff_gt_1_4) clr_tmr   = 1'b1;
        else if (tmr_full)    nxt_state = STEER_EN;
      end
      STEER_EN: begin
        if (!sum_ok)            nxt_state = IDLE;
        else if (diff_gt_15_16) nxt_state = WAIT;
      end
      default: nxt_state = IDLE;
    endcase
    if (!pwr_up) nxt_state = IDLE;

    // Counting only while staying in WAIT means every entry starts from zero.
    if ((state == WAIT) && (nxt_state == WAIT) && !clr_tmr) tmr_nxt = tmr + 26'd1;
    else                                                     tmr_nxt = 26'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tmr       <= 26'd0;
      en_steer  <= 1'b0;
      rider_off <= 1'b1;
    end else begin
      state     <= nxt_state;
      tmr       <= tmr_nxt;
      en_steer  <= (nxt_state == STEER_EN);
      rider_off <= (nxt_state == IDLE);
    end
  end

endmodule

// File: tb/tb_rider_steer_seq.sv
// Purpose : directed self-checking bench for rider_steer_seq (fast_sim=1).
// Latency : n/a.
// Backpress: n/a.
module tb_rider_steer_seq;

  logic        clk;
  logic        rst_n;
  logic        pwr_up;
  logic        ld_vld;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic        en_steer;
  logic        rider_off;

  int n_tests = 0;
  int n_fail  = 0;

  rider_steer_seq #(.fast_sim(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pwr_up   (pwr_up),
    .ld_vld   (ld_vld),
    .lft_ld   (lft_ld),
    .rght_ld  (rght_ld),
    .en_steer (en_steer),
    .rider_off(rider_off)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] lft;
    logic [11:0] rght;
    logic        pwr;
    logic        exp_en;
    logic        exp_off;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One-cycle strobe, then one more edge: outputs then reflect the new sample.
  task automatic strobe(input logic [11:0] l, input logic [11:0] r);
    lft_ld  = l;
    rght_ld = r;
    ld_vld  = 1'b1;
    tick();
    ld_vld  = 1'b0;
    tick();
  endtask

  task automatic check_out(input string name, input logic exp_en, input logic exp_off);
    check({name, ".en_steer"}, {31'd0, en_steer}, {31'd0, exp_en});
    check({name, ".rider_off"}, {31'd0, rider_off}, {31'd0, exp_off});
  endtask

  initial begin
    //           lft     rght    pwr   en    off
    vecs[0] = '{12'h100, 12'h100, 1'b1, 1'b0, 1'b1}; // sum 0x200 in IDLE: stay
    vecs[1] = '{12'h120, 12'h120, 1'b1, 1'b0, 1'b1}; // sum 0x240 not > 0x240
    vecs[2] = '{12'h121, 12'h120, 1'b1, 1'b0, 1'b0}; // sum 0x241 -> WAIT
    vecs[3] = '{12'h0E1, 12'h0E0, 1'b1, 1'b0, 1'b0}; // sum 0x1C1 > 0x1C0: stay WAIT
    vecs[4] = '{12'h0E0, 12'h0E0, 1'b1, 1'b0, 1'b1}; // sum 0x1C0 -> IDLE
    vecs[5] = '{12'h150, 12'h150, 1'b1, 1'b0, 1'b0}; // mount -> WAIT
    vecs[6] = '{12'h150, 12'h150, 1'b0, 1'b0, 1'b1}; // power down -> IDLE
    vecs[7] = '{12'h150, 12'h150, 1'b1, 1'b0, 1'b0}; // power back -> WAIT
    vecs[8] = '{12'h000, 12'h000, 1'b1, 1'b0, 1'b1}; // empty -> IDLE

    rst_n   = 1'b0;
    pwr_up  = 1'b1;
    ld_vld  = 1'b0;
    lft_ld  = 12'h000;
    rght_ld = 12'h000;
    repeat (3) tick();
    check_out("reset", 1'b0, 1'b1);
    check("reset.tmr", {6'd0, dut.tmr}, 32'd0);
    rst_n = 1'b1;
    tick();
    check_out("post_reset", 1'b0, 1'b1);

    for (int i = 0; i < 9; i++) begin
      pwr_up = vecs[i].pwr;
      strobe(vecs[i].lft, vecs[i].rght);
      check_out($sformatf("vec%0d", i), vecs[i].exp_en, vecs[i].exp_off);
    end
    pwr_up = 1'b1;

    // Latency: sample at edge N, state/outputs at edge N+1.
    lft_ld  = 12'h150;
    rght_ld = 12'h150;
    ld_vld  = 1'b1;
    tick();
    ld_vld  = 1'b0;
    check("lat_1clk.rider_off", {31'd0, rider_off}, 32'd1);
    tick();
    check("lat_2clk.rider_off", {31'd0, rider_off}, 32'd0);

    // Timer counts from zero on entry; then async reset mid-WAIT.
    repeat (100) tick();
    check("wait_tmr100", {6'd0, dut.tmr}, 32'd100);
    #2 rst_n = 1'b0;
    #1;
    check_out("async_rst", 1'b0, 1'b1);
    #1 rst_n = 1'b1;
    tick();
    check("async_rst.tmr", {6'd0, dut.tmr}, 32'd0);
    check_out("after_rst", 1'b0, 1'b1);

    // Mount, imbalance halfway, rebalance, full count from the rebalance.
    strobe(12'h150, 12'h150);
    check_out("mount", 1'b0, 1'b0);
    repeat (16000) tick();
    check("half.tmr", {6'd0, dut.tmr}, 32'd16000);
    check_out("half", 1'b0, 1'b0);
    strobe(12'h200, 12'h080);
    repeat (5) tick();
    check("imbal.tmr", {6'd0, dut.tmr}, 32'd0);
    check_out("imbal", 1'b0, 1'b0);
    strobe(12'h150, 12'h150);
    repeat (32766) tick();
    check_out("rebal_early", 1'b0, 1'b0);
    tick();
    check_out("rebal_expire", 1'b1, 1'b0);

    // Power-down from STEER_EN with a heavy balanced load.
    strobe(12'h180, 12'h180);
    check_out("heavy", 1'b1, 1'b0);
    pwr_up = 1'b0;
    tick();
    check_out("pwrdn_edge", 1'b0, 1'b1);
    repeat (3) tick();
    check_out("pwrdn_hold", 1'b0, 1'b1);
    pwr_up = 1'b1;
    tick();
    check_out("pwrup_wait", 1'b0, 1'b0);
    repeat (32767) tick();
    check_out("pwrup_early", 1'b0, 1'b0);
    tick();
    check_out("pwrup_expire", 1'b1, 1'b0);

    // STEER_EN hysteresis, 15/16 boundary, step-off.
    strobe(12'h100, 12'h100);
    check_out("steer_hyst", 1'b1, 1'b0);
    strobe(12'h1F0, 12'h010);
    check_out("steer_1516_edge", 1'b1, 1'b0);
    strobe(12'h280, 12'h000);
    check_out("stepoff_wait", 1'b0, 1'b0);
    strobe(12'h0E0, 12'h0E0);
    check_out("stepoff_idle", 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rider_steer_seq.md
# rider_steer_seq

Rider-detection and steering-enable sequencer feeding balance_cntrl's `rider_off` and `en_steer` inputs. It samples the left and right load-cell readings from the A2D interface and applies weight hysteresis and left/right balance checks. A settle timer enables steering only after the rider has stood balanced for ~1.34 s. The block also forces the safe state whenever `pwr_up` is low.

## Interface
- `fast_sim`, default 1: selects the settle-timer terminal count; 1 gives 2^15 cycles, 0 gives 2^26 cycles (~1.34 s at 50 MHz).
- `MIN_RIDER_WT`, default 12'h200: nominal rider-present weight threshold.
- `WT_HYSTERESIS`, default 12'h040: hysteresis half-band applied around `MIN_RIDER_WT`.
- `clk` in 1: 50 MHz system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `pwr_up` in 1: Segway powered up; when low, the block is held in IDLE.
- `ld_vld` in 1: single-cycle strobe; the load-cell values are valid in that cycle.
- `lft_ld` in 12: left load cell, unsigned.
- `rght_ld` in 12: right load cell, unsigned.
- `en_steer` out 1: registered; 1 only in state STEER_EN.
- `rider_off` out 1: registered; 1 only in state IDLE.

## Operation
- **Sampling:** on `ld_vld`, `lft_ld` and `rght_ld` are latched into `lft_q` and `rght_q`. Between strobes the latched values hold. All decisions use the latched values.
- **Arithmetic:**
  - `sum` = `lft_q` + `rght_q`, 13-bit unsigned.
  - `diff` = |`lft_q` − `rght_q`|, 12-bit unsigned. It is computed from a 13-bit signed subtraction.
  - `diff_gt_1_4` = `diff` > (`sum` >> 2).
  - `diff_gt_15_16` = `diff` > (`sum` − (`sum` >> 4)).
  - All comparisons are unsigned, 13-bit, with zero-extension.
- **Weight hysteresis:**
  - In IDLE: `sum_ok` = `sum` > `MIN_RIDER_WT` + `WT_HYSTERESIS`.
  - In WAIT or STEER_EN: `sum_ok` = `sum` > `MIN_RIDER_WT` − `WT_HYSTERESIS`.
- **Settle timer:**
  - 26-bit up-counter; increments only in WAIT.
  - Cleared on any entry to WAIT, on `clr_tmr`, and in every other state.
  - `tmr_full` = `tmr[14:0]` all ones when `fast_sim`=1; `tmr[25:0]` all ones when `fast_sim`=0.
- **FSM, 3 states; reset state IDLE:**
  - IDLE: if `sum_ok`, go to WAIT with the timer cleared; otherwise stay.
  - WAIT:
    - if !`sum_ok`, go to IDLE;
    - else if `diff_gt_1_4`, assert `clr_tmr` and stay;
    - else if `tmr_full`, go to STEER_EN;
    - else stay with the timer counting.
  - STEER_EN:
    - if !`sum_ok`, go to IDLE;
    - else if `diff_gt_15_16`, go to WAIT with the timer cleared;
    - else stay.
  - Any state: `pwr_up`=0 forces IDLE on the next edge and clears the timer. This has priority over all other transitions.
- **Outputs** are decoded from the next state and registered, so they change on the same edge as the state.

## Timing
- **Reset values:**
  - state IDLE; `lft_q`, `rght_q`, timer = 0.
  - `en_steer` = 0, `rider_off` = 1.
- **Latency:** `ld_vld` at cycle N latches the data at the edge ending N. The FSM evaluates in N+1, so outputs change at the edge ending N+1, i.e. 2 clocks after the strobe.
- **Timer expiry:** `en_steer` rises on the edge where WAIT sees `tmr_full`. Minimum dwell in WAIT is 2^15 cycles (`fast_sim`=1) or 2^26 cycles (`fast_sim`=0).
- **Simultaneous events:**
  - `sum_ok` loss has priority over the diff checks.
  - `pwr_up`=0 has priority over everything.
  - `ld_vld` arriving on the same cycle as `tmr_full` does not change the decision in that cycle; the new data applies from the next cycle.
- **Mid-operation reset:** asynchronous reset at any point returns to IDLE immediately; outputs go to their reset values without waiting for a clock.
- **Timer wrap:** impossible, because the timer leaves WAIT at `tmr_full`. If `clr_tmr` and `tmr_full` coincide, `clr_tmr` wins.

## Structure
- Shared package `segway_pkg` holds:
  - the state typedef `rider_state_t` {IDLE, WAIT, STEER_EN};
  - the defaults for `MIN_RIDER_WT` and `WT_HYSTERESIS`;
  - the terminal-count constants `TMR_BITS_FAST` = 15 and `TMR_BITS_SLOW` = 26.
- One sub-module, `ld_cell_cmp`: purely combinational. It takes `lft_q`, `rght_q` and a `hyst_hi` select, and outputs `sum_ok`, `diff_gt_1_4` and `diff_gt_15_16`.
- The FSM, timer and sample registers live in the top module.

## Test plan
- **Reset:** assert `rst_n`=0 mid-WAIT → `en_steer`=0 and `rider_off`=1 immediately; the timer reads 0 after release.
- **Mount:** lft=0x150, rght=0x150 (sum 0x2A0 > 0x240) → `rider_off` falls 2 clocks after `ld_vld`; `en_steer` rises exactly 2^15 cycles later (`fast_sim`=1).
- **Imbalance in WAIT:** lft=0x200, rght=0x080 (`diff` 0x180 > 0xA0) applied halfway through the count → timer restarts; `en_steer` stays 0 until the load is balanced plus 2^15 further cycles.
- **Step-off:**
  - In STEER_EN, lft=0x280, rght=0x000 (`diff` 0x280 > 0x258) → WAIT, `en_steer`=0, `rider_off`=0.
  - Then lft=rght=0x0E0 (sum 0x1C0, not > 0x1C0) → IDLE, `rider_off`=1.
- **Hysteresis:**
  - sum 0x200 from IDLE → stays IDLE.
  - sum 0x200 while in STEER_EN → stays STEER_EN.
- **Power-down:** `pwr_up` dropped in STEER_EN with a heavy balanced load → IDLE on the next edge. `pwr_up` restored → the sequence restarts through WAIT with a full timer count.
